// File: rtl/deser_word_align.sv
// Serial-to-parallel deserializer with sync-pattern word alignment.
// A SEARCH phase hunts bit-by-bit for SYNC_PATTERN. CONFIRM checks that the
// pattern repeats on consecutive word boundaries. Once LOCKED, one word is
// emitted every WIDTH clocks with a single-cycle valid strobe.
module deser_word_align #(
    parameter int                 WIDTH        = 16,
    parameter logic [WIDTH-1:0]   SYNC_PATTERN = 16'hA5C3,
    parameter int                 LOCK_COUNT   = 3
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             din,
    input  logic             realign,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    logic             boundary;
    logic             match;
    logic [3:0]       mcnt_inc;

    // Next-state and output decode; the window and bit counter advance every edge.
    always_comb begin
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        // New bit enters at the MSB so the first-received bit ends in bit 0.
        win_d    = {din, win_q[WIDTH-1:1]};
        boundary = (bcnt_q == BW'(WIDTH - 1));
        bcnt_d   = boundary ? '0 : BW'(bcnt_q + 1'b1);
        match    = (win_d == SYNC_PATTERN);
        mcnt_inc = 4'(mcnt_q + 4'd1);

        if (realign) begin
            // Realign takes priority over any boundary action, including output.
            state_d = SEARCH;
            mcnt_d  = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (match) begin
                        // Restart framing so the next bit is bit 0 of a new word.
                        bcnt_d  = '0;
                        mcnt_d  = 4'd1;
                        state_d = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (boundary) begin
                        if (match) begin
                            mcnt_d = mcnt_inc;
                            if (mcnt_inc == 4'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            sync_err_d = 1'b1;
                            mcnt_d     = '0;
                            state_d    = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // Sync words in lock are ordinary data; no auto-unlock.
                    if (boundary) begin
                        dout_d       = win_d;
                        dout_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    mcnt_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= SEARCH;
            win_q        <= '0;
            bcnt_q       <= '0;
            mcnt_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            bcnt_q       <= bcnt_d;
            mcnt_q       <= mcnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

endmodule
